sr_param_sequencer: RTL and testbench
=====================================

# sr_param_sequencer

Synchronous configuration controller for the stretch-reflex loop. It takes host parameter writes as a 32-bit value on two 16-bit wires plus a per-slot trigger, and holds them in a shadow bank. On each simulation-step tick it commits the pending (dirty) slots into the active bank. Spindle, MN pool, muscle and clock generator therefore see parameter changes only between simulation steps, with a stable-flag handshake, and never mid-step.

## Interface

- NUM_SLOTS, 10: number of 32-bit parameter slots; trigger bit n writes slot n.
- HALF_CNT_SLOT, 9: index of the clock half-count slot; a write of zero to it is rejected.

- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wire_lo  in  16  low half of the write data.
- wire_hi  in  16  high half of the write data.
- trig  in  NUM_SLOTS  one-cycle write strobes, one bit per slot.
- tick  in  1  one-cycle simulation-step strobe, already synchronous to clk.
- clr_err  in  1  one-cycle pulse that clears the sticky error flags.
- cfg_flat  out  NUM_SLOTS*32  active bank; slot n occupies bits [n*32 +: 32].
- cfg_stable  out  1  high when the active bank is not changing.
- commit_done  out  1  one-cycle pulse when a commit completes.
- busy  out  1  high while in SCAN or DONE.
- dirty  out  NUM_SLOTS  per slot: shadow holds a value not yet committed.
- err_zero  out  1  sticky: a zero was written to HALF_CNT_SLOT.
- err_overrun  out  1  sticky: a tick arrived while busy.

## Operation

- Reset, asynchronous: shadow and active banks load the package defaults.
  - dirty=0, err_zero=0, err_overrun=0.
  - cfg_stable=1, commit_done=0, busy=0; FSM=IDLE; scan index=0.
- Write, any state: for every set bit n of trig, shadow[n] <= {wire_hi, wire_lo} and dirty[n] <= 1.
  - Several bits set in one cycle: all of those slots get the same data.
- Zero-write guard: trig[HALF_CNT_SLOT] with {wire_hi, wire_lo}==0.
  - The shadow is not written and dirty is unchanged for that slot.
  - err_zero <= 1. Other slots triggered in the same cycle are written normally.
- FSM:
  - IDLE: on tick with |dirty, go to SCAN with idx=0 and cfg_stable=0. On tick with dirty==0, stay in IDLE with no pulse.
  - SCAN: each cycle, if dirty[idx], then active[idx] <= shadow[idx] and dirty[idx] <= 0. idx increments each cycle; after idx==NUM_SLOTS-1, go to DONE.
  - DONE: commit_done=1 for one cycle, cfg_stable <= 1, then go to IDLE.
- Write and copy of the same slot in the same cycle:
  - The copy takes the old shadow value.
  - The new value lands in shadow and dirty stays 1, so it commits on the next tick.
- Write during SCAN to a slot whose idx is not yet reached: the new value is committed in this pass.
- Write during SCAN to a slot already passed: it stays dirty for the next tick.
- tick while busy: ignored and err_overrun <= 1. The commit in progress is unaffected.
- clr_err in the same cycle as a new error event: the set wins.
- reset_n asserted mid-SCAN: immediate return to reset state. The active bank reverts to defaults; a partial commit is discarded.

## Timing

- Write to shadow: 1 cycle, so dirty[n] is visible the cycle after trig.
- tick in cycle t:
  - cfg_stable falls and busy rises at t+1.
  - Slot k is copied at edge t+1+k.
  - commit_done is high and cfg_stable rises at cycle t+NUM_SLOTS+1.
  - busy falls at t+NUM_SLOTS+2.
- Fixed commit length: NUM_SLOTS+1 cycles, regardless of how many slots are dirty.
- Minimum spacing between ticks without overrun: NUM_SLOTS+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Package sr_cfg_pkg holds:
  - Slot index constants: PPS_COEF_IA=0, LEN_PXI=1, GAIN=2, GAMMA_DYN=3, GAMMA_STA=4, GAIN_MN=5, BDAMP_1=6, BDAMP_2=7, BDAMP_CHAIN=8, HALF_CNT=9.
  - The default array: 3F66_6666, 3F66_6666, 0000_0000, 42A0_0000, 42A0_0000, 0000_0001, 3E71_4120, 3D14_4674, 3C58_44D0, 0000_017D.
  - FSM state encoding: IDLE, SCAN, DONE.
- One natural sub-module, sr_shadow_bank: shadow registers, dirty bits and zero guard.
  - The top level keeps the FSM, the active bank and the error flags.

## Test plan

- Reset release, no activity → cfg_flat equals the package defaults; cfg_stable=1; dirty=0; no commit_done on a tick.
- Write 0x4120_0000 to slot 3, then tick at cycle t → dirty=0x008 before the tick; slot 3 changes at t+4; commit_done at t+11; other slots unchanged.
- trig=0x201 with data 0 → slot 0 becomes dirty with value 0; slot 9 stays clean; err_zero=1. clr_err then clears err_zero.
- During SCAN: write slot 1 at idx=3 and slot 8 at idx=3 → slot 8 commits this pass; slot 1 stays dirty, and a second tick commits it.
- Second tick 5 cycles after the first → err_overrun=1; exactly one commit_done pulse.
- reset_n low at idx=5 with slots 2 and 7 dirty → cfg_flat returns to defaults; dirty=0; FSM=IDLE; cfg_stable=1.

Source files
------------

// File: rtl/sr_cfg_pkg.sv
// Shared constants, defaults and FSM encoding for the stretch-reflex parameter sequencer.
// Slot n of a bank occupies bits [n*32 +: 32].
package sr_cfg_pkg;

  localparam int unsigned NUM_SLOTS = 10;
  localparam int unsigned IDX_W     = 4;

  localparam int unsigned PPS_COEF_IA = 0;
  localparam int unsigned LEN_PXI     = 1;
  localparam int unsigned GAIN        = 2;
  localparam int unsigned GAMMA_DYN   = 3;
  localparam int unsigned GAMMA_STA   = 4;
  localparam int unsigned GAIN_MN     = 5;
  localparam int unsigned BDAMP_1     = 6;
  localparam int unsigned BDAMP_2     = 7;
  localparam int unsigned BDAMP_CHAIN = 8;
  localparam int unsigned HALF_CNT    = 9;

  localparam int unsigned HALF_CNT_SLOT = HALF_CNT;

  typedef logic [NUM_SLOTS-1:0][31:0] bank_t;

  // Concatenation lists slot 9 first so that slot 0 lands in the low word.
  localparam bank_t CFG_DEFAULTS = {
    32'h0000_017D, 32'h3C58_44D0, 32'h3D14_4674, 32'h3E71_4120, 32'h0000_0001,
    32'h42A0_0000, 32'h42A0_0000, 32'h0000_0000, 32'h3F66_6666, 32'h3F66_6666
  };

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

endpackage

// File: rtl/sr_shadow_bank.sv
// Host-facing shadow bank: per-slot write strobes, dirty tracking and the zero guard on the
// clock half-count slot.
module sr_shadow_bank
  import sr_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          wire_lo,
  input  logic [15:0]          wire_hi,
  input  logic [NUM_SLOTS-1:0] trig,
  input  logic                 copy_en,
  input  logic [IDX_W-1:0]     copy_idx,
  output bank_t                shadow,
  output logic [NUM_SLOTS-1:0] dirty,
  output logic                 zero_hit
);

  logic [31:0]          wdata;
  logic [NUM_SLOTS-1:0] wr_en;
  logic [NUM_SLOTS-1:0] dirty_d;
  logic [NUM_SLOTS-1:0] dirty_q;
  bank_t                shadow_q;

  assign wdata = {wire_hi, wire_lo};

  always_comb begin
    wr_en    = trig;
    zero_hit = trig[HALF_CNT_SLOT] && (wdata == 32'h0);
    if (zero_hit) wr_en[HALF_CNT_SLOT] = 1'b0;
  end

  // A write landing on the slot being copied keeps it dirty for the next tick.
  always_comb begin
    dirty_d = dirty_q;
    if (copy_en) dirty_d[copy_idx] = 1'b0;
    dirty_d = dirty_d | wr_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= CFG_DEFAULTS;
      dirty_q  <= '0;
    end else begin
      for (int n = 0; n < NUM_SLOTS; n++) begin
        if (wr_en[n]) shadow_q[n] <= wdata;
      end
      dirty_q <= dirty_d;
    end
  end

  assign shadow = shadow_q;
  assign dirty  = dirty_q;

endmodule

// File: rtl/sr_param_sequencer.sv
// Commits dirty shadow slots into the active bank once per simulation-step tick, so
// downstream blocks only ever see parameter changes between steps.
module sr_param_sequencer
  import sr_cfg_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             wire_lo,
  input  logic [15:0]             wire_hi,
  input  logic [NUM_SLOTS-1:0]    trig,
  input  logic                    tick,
  input  logic                    clr_err,
  output logic [NUM_SLOTS*32-1:0] cfg_flat,
  output logic                    cfg_stable,
  output logic                    commit_done,
  output logic                    busy,
  output logic [NUM_SLOTS-1:0]    dirty,
  output logic                    err_zero,
  output logic                    err_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  bank_t            active_q;
  bank_t            shadow;
  logic             copy_en;
  logic             zero_hit;

  assign copy_en = (state_q == StScan) && dirty[idx_q];

  sr_shadow_bank u_shadow (
    .clk      (clk),
    .reset_n  (reset_n),
    .wire_lo  (wire_lo),
    .wire_hi  (wire_hi),
    .trig     (trig),
    .copy_en  (copy_en),
    .copy_idx (idx_q),
    .shadow   (shadow),
    .dirty    (dirty),
    .zero_hit (zero_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      active_q    <= CFG_DEFAULTS;
      cfg_stable  <= 1'b1;
      commit_done <= 1'b0;
      busy        <= 1'b0;
      err_zero    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      commit_done <= 1'b0;

      // Error set takes priority over a simultaneous clear.
      if (zero_hit)     err_zero <= 1'b1;
      else if (clr_err) err_zero <= 1'b0;
      if (tick && busy) err_overrun <= 1'b1;
      else if (clr_err) err_overrun <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (tick && (|dirty)) begin
            state_q    <= StScan;
            idx_q      <= '0;
            cfg_stable <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StScan: begin
          if (copy_en) active_q[idx_q] <= shadow[idx_q];
          if (idx_q == LAST_IDX) begin
            state_q     <= StDone;
            commit_done <= 1'b1;
            cfg_stable  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_flat = active_q;

endmodule

// File: tb/tb_sr_param_sequencer.sv
// Bench for sr_param_sequencer: directed vector table, hand-written commit corner cases and a
// randomized run checked every cycle against a step-count reference model.
module tb_sr_param_sequencer;
  import sr_cfg_pkg::*;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [15:0]    wire_lo = '0;
  logic [15:0]    wire_hi = '0;
  logic [9:0]     trig = '0;
  logic           tick = 1'b0;
  logic           clr_err = 1'b0;
  logic [319:0]   cfg_flat;
  logic           cfg_stable, commit_done, busy, err_zero, err_overrun;
  logic [9:0]     dirty;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  sr_param_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wire_lo     (wire_lo),
    .wire_hi     (wire_hi),
    .trig        (trig),
    .tick        (tick),
    .clr_err     (clr_err),
    .cfg_flat    (cfg_flat),
    .cfg_stable  (cfg_stable),
    .commit_done (commit_done),
    .busy        (busy),
    .dirty       (dirty),
    .err_zero    (err_zero),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: m_cnt counts cycles since an accepted tick (0 = idle, 1..10 = slot
  // m_cnt-1 is being copied, 11 = commit done cycle).
  logic [31:0] m_sh [10];
  logic [31:0] m_act[10];
  logic [9:0]  m_dirty;
  int          m_cnt;
  logic        m_ez, m_eo;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 10; n++) begin
        m_sh[n]  = CFG_DEFAULTS[n];
        m_act[n] = CFG_DEFAULTS[n];
      end
      m_dirty = '0; m_cnt = 0; m_ez = 1'b0; m_eo = 1'b0;
    end else begin
      automatic logic [31:0] wd = {wire_hi, wire_lo};
      automatic logic any_d = |m_dirty;
      automatic int   old_cnt = m_cnt;
      automatic logic zero = trig[9] && (wd == 32'h0);
      if (m_cnt >= 1 && m_cnt <= 10 && m_dirty[m_cnt-1]) begin
        m_act[m_cnt-1]   = m_sh[m_cnt-1];
        m_dirty[m_cnt-1] = 1'b0;
      end
      for (int n = 0; n < 10; n++) begin
        if (trig[n] && !(n == 9 && zero)) begin
          m_sh[n] = wd; m_dirty[n] = 1'b1;
        end
      end
      if (m_cnt != 0) m_cnt = (m_cnt == 11) ? 0 : m_cnt + 1;
      else if (tick && any_d) m_cnt = 1;
      m_ez = zero ? 1'b1 : (clr_err ? 1'b0 : m_ez);
      m_eo = (tick && old_cnt != 0) ? 1'b1 : (clr_err ? 1'b0 : m_eo);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      automatic logic [319:0] ef;
      automatic logic [4:0] ectl, actl;
      for (int n = 0; n < 10; n++) ef[n*32 +: 32] = m_act[n];
      ectl = {m_cnt != 0, m_cnt == 11, !(m_cnt >= 1 && m_cnt <= 10), m_ez, m_eo};
      actl = {busy, commit_done, cfg_stable, err_zero, err_overrun};
      chk("model_flat", cfg_flat, ef);
      chk("model_dirty", 320'(dirty), 320'(m_dirty));
      chk("model_ctrl busy/done/stable/ez/eo", 320'(actl), 320'(ectl));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input logic [9:0] tg, input logic [31:0] d, input logic tk,
                       input logic clr);
    trig = tg; {wire_hi, wire_lo} = d; tick = tk; clr_err = clr;
  endtask

  task automatic idle_in();
    drive(10'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    nxt(); idle_in(); reset_n = 1'b0;
    nxt(); nxt(); reset_n = 1'b1;
    nxt();
  endtask

  typedef struct {
    logic [9:0]  tg;
    logic [31:0] data;
    logic        clr;
    logic [9:0]  exp_dirty;
    logic        exp_ez;
  } vec_t;

  vec_t  vecs[6];
  bank_t eb;
  int    pulses;

  initial begin
    vecs[0] = '{10'h008, 32'h4120_0000, 1'b0, 10'h008, 1'b0};
    vecs[1] = '{10'h201, 32'h0000_0000, 1'b0, 10'h009, 1'b1};
    vecs[2] = '{10'h200, 32'h0000_017E, 1'b0, 10'h209, 1'b1};
    vecs[3] = '{10'h000, 32'h0000_0000, 1'b1, 10'h209, 1'b0};
    vecs[4] = '{10'h0C0, 32'h1234_5678, 1'b0, 10'h2C9, 1'b0};
    vecs[5] = '{10'h200, 32'h0000_0000, 1'b1, 10'h2C9, 1'b1};

    do_reset();
    chk_on = 1'b1;

    // Reset state and a tick with nothing dirty.
    chk("reset_flat", cfg_flat, CFG_DEFAULTS);
    chk("reset_dirty", 320'(dirty), 320'(0));
    chk("reset_stable", 320'(cfg_stable), 320'(1));
    chk("reset_busy", 320'(busy), 320'(0));
    tick = 1'b1; nxt(); tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin nxt(); pulses += int'(commit_done); end
    chk("clean_tick_no_done", 320'(pulses), 320'(0));

    // Table vectors, cumulative, no tick.
    foreach (vecs[i]) begin
      drive(vecs[i].tg, vecs[i].data, 1'b0, vecs[i].clr);
      nxt(); idle_in();
      chk("vec_dirty", 320'(dirty), 320'(vecs[i].exp_dirty));
      chk("vec_err_zero", 320'(err_zero), 320'(vecs[i].exp_ez));
      chk("vec_flat_unchanged", cfg_flat, CFG_DEFAULTS);
      nxt();
    end
    tick = 1'b1; nxt(); tick = 1'b0;
    for (int i = 0; i < 13; i++) nxt();
    eb = CFG_DEFAULTS;
    eb[0] = 32'h0; eb[3] = 32'h4120_0000; eb[6] = 32'h1234_5678; eb[7] = 32'h1234_5678;
    eb[9] = 32'h0000_017E;
    chk("table_commit_flat", cfg_flat, eb);
    chk("table_commit_dirty", 320'(dirty), 320'(0));

    // Commit timing, tick in cycle t.
    drive(10'h008, 32'hCAFE_0003, 1'b0, 1'b1); nxt(); idle_in();
    chk("timing_dirty_before", 320'(dirty), 320'(10'h008));
    tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      nxt(); tick = 1'b0;
      if (c == 1) begin
        chk("t1_busy", 320'(busy), 320'(1));
        chk("t1_stable", 320'(cfg_stable), 320'(0));
      end
      if (c == 3) chk("t3_slot3_old", 320'(cfg_flat[96 +: 32]), 320'(32'h4120_0000));
      if (c == 5) chk("t5_slot3_new", 320'(cfg_flat[96 +: 32]), 320'(32'hCAFE_0003));
      if (c == 10) chk("t10_done_low", 320'(commit_done), 320'(0));
      if (c == 11) begin
        chk("t11_done", 320'(commit_done), 320'(1));
        chk("t11_stable", 320'(cfg_stable), 320'(1));
        chk("t11_busy", 320'(busy), 320'(1));
      end
      if (c == 12) begin
        chk("t12_done_low", 320'(commit_done), 320'(0));
        chk("t12_busy_low", 320'(busy), 320'(0));
      end
    end
    eb[3] = 32'hCAFE_0003;
    chk("timing_others_kept", cfg_flat, eb);

    // Writes during SCAN at idx=3: slot 8 is ahead, slot 1 already passed.
    drive(10'h010, 32'h1111_1111, 1'b0, 1'b0); nxt(); idle_in();
    tick = 1'b1; nxt(); tick = 1'b0;
    for (int c = 2; c <= 4; c++) nxt();
    drive(10'h102, 32'hAAAA_5555, 1'b0, 1'b0); nxt(); idle_in();
    for (int c = 6; c <= 13; c++) nxt();
    chk("scan_slot8_now", 320'(cfg_flat[256 +: 32]), 320'(32'hAAAA_5555));
    chk("scan_slot1_old", 320'(cfg_flat[32 +: 32]), 320'(32'h3F66_6666));
    chk("scan_slot4", 320'(cfg_flat[128 +: 32]), 320'(32'h1111_1111));
    chk("scan_dirty_left", 320'(dirty), 320'(10'h002));
    tick = 1'b1; nxt(); tick = 1'b0;
    for (int c = 0; c < 13; c++) nxt();
    chk("scan_slot1_next", 320'(cfg_flat[32 +: 32]), 320'(32'hAAAA_5555));
    chk("scan_dirty_clean", 320'(dirty), 320'(0));

    // Overrun: second tick five cycles after the first.
    drive(10'h020, 32'h0000_0007, 1'b0, 1'b0); nxt(); idle_in();
    tick = 1'b1; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      nxt(); tick = (i == 5);
      pulses += int'(commit_done);
    end
    chk("overrun_flag", 320'(err_overrun), 320'(1));
    chk("overrun_one_done", 320'(pulses), 320'(1));
    clr_err = 1'b1; nxt(); clr_err = 1'b0;
    chk("overrun_cleared", 320'(err_overrun), 320'(0));

    // Reset at idx=5 with slots 2 and 7 dirty discards the partial commit.
    drive(10'h084, 32'h0000_0055, 1'b0, 1'b0); nxt(); idle_in();
    tick = 1'b1; nxt(); tick = 1'b0;
    for (int c = 2; c <= 6; c++) nxt();
    chk("midscan_slot2_copied", 320'(cfg_flat[64 +: 32]), 320'(32'h55));
    #1 reset_n = 1'b0;
    #1;
    chk("rst_flat", cfg_flat, CFG_DEFAULTS);
    chk("rst_dirty", 320'(dirty), 320'(0));
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_stable", 320'(cfg_stable), 320'(1));
    nxt(); reset_n = 1'b1;
    nxt(); tick = 1'b1; nxt(); tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 13; i++) begin nxt(); pulses += int'(commit_done); end
    chk("post_rst_no_done", 320'(pulses), 320'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      automatic logic [9:0] tg = '0;
      automatic logic [31:0] d = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 4) == 0) tg[$urandom_range(0, 9)] = 1'b1;
      if ($urandom_range(0, 15) == 0) tg = tg | 10'($urandom);
      drive(tg, d, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      nxt();
    end
    idle_in();
    nxt(); nxt();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
